// File: rtl/frame_ram_loader_if.sv
// Byte-stream input and RAM write port of the frame loader, bundled as one interface.
// master: host byte source plus RAM side; slave: the loader itself.
interface frame_ram_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] wraddress;
    logic [7:0]  data;
    logic        wren;

    modport master (
        output in_data, in_valid,
        input  in_ready, wraddress, data, wren
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wraddress, data, wren
    );
endinterface

// File: rtl/frame_ram_loader.sv
// Frame RAM write side: parses a 4-byte big-endian width/height header, then
// writes width*height greyscale pixels row-major starting at BASE_ADDRESS.
module frame_ram_loader #(
    parameter logic [17:0] BASE_ADDRESS = 18'h10,
    parameter int          MAX_W        = 400,
    parameter int          MAX_H        = 433
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    frame_ram_loader_if.slave   bus,
    output logic [9:0]          img_width,
    output logic [9:0]          img_height,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int          FRAME_END = int'(BASE_ADDRESS) + MAX_W * MAX_H;
    localparam logic [15:0] MAX_W16   = 16'(MAX_W);
    localparam logic [15:0] MAX_H16   = 16'(MAX_H);

    generate
        if (FRAME_END > (1 << 18)) begin : g_bad_cfg
            $error("frame_ram_loader: image area does not fit the 18-bit address space");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  hdr_cnt_reg;
    logic [7:0]  w_hi_reg, w_lo_reg, h_hi_reg;
    logic [9:0]  x_reg, y_reg, width_reg, height_reg;
    logic [17:0] offset_reg, wraddress_reg;
    logic [7:0]  data_reg;
    logic        wren_reg;
    logic        in_ready_reg, busy_reg, done_reg, error_reg;
    logic        in_ready_next, busy_next, done_next, error_next;
    logic        accept, last_pixel, hdr_ok;
    logic [15:0] hdr_w, hdr_h;

    assign accept     = bus.in_valid && in_ready_reg;
    assign hdr_w      = {w_hi_reg, w_lo_reg};
    // Height low byte is the byte being accepted right now (4th header byte).
    assign hdr_h      = {h_hi_reg, bus.in_data};
    assign hdr_ok     = (hdr_w != 16'd0) && (hdr_h != 16'd0) &&
                        (hdr_w <= MAX_W16) && (hdr_h <= MAX_H16);
    assign last_pixel = (x_reg == width_reg - 10'd1) && (y_reg == height_reg - 10'd1);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = HDR;
            HDR:  if (accept && hdr_cnt_reg == 2'd3) state_next = hdr_ok ? LOAD : ERR;
            LOAD: if (accept && last_pixel) state_next = DONE;
            DONE: state_next = IDLE;
            ERR:  if (start) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are flop outputs.
    always_comb begin
        in_ready_next = (state_next == HDR) || (state_next == LOAD);
        busy_next     = in_ready_next;
        done_next     = (state_next == DONE);
        error_next    = (state_next == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            in_ready_reg <= in_ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_reg   <= 2'd0;
            w_hi_reg      <= 8'd0;
            w_lo_reg      <= 8'd0;
            h_hi_reg      <= 8'd0;
            x_reg         <= 10'd0;
            y_reg         <= 10'd0;
            width_reg     <= 10'd0;
            height_reg    <= 10'd0;
            offset_reg    <= 18'd0;
            wraddress_reg <= 18'd0;
            data_reg      <= 8'd0;
            wren_reg      <= 1'b0;
        end else begin
            wren_reg <= 1'b0;
            if ((state_reg == IDLE || state_reg == ERR) && start)
                hdr_cnt_reg <= 2'd0;
            if (state_reg == HDR && accept) begin
                hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                case (hdr_cnt_reg)
                    2'd0: w_hi_reg <= bus.in_data;
                    2'd1: w_lo_reg <= bus.in_data;
                    2'd2: h_hi_reg <= bus.in_data;
                    default: begin
                        if (hdr_ok) begin
                            width_reg  <= hdr_w[9:0];
                            height_reg <= hdr_h[9:0];
                            x_reg      <= 10'd0;
                            y_reg      <= 10'd0;
                            offset_reg <= 18'd0;
                        end
                    end
                endcase
            end
            // Running linear offset replaces y*width+x; x/y only detect the end.
            if (state_reg == LOAD && accept) begin
                wren_reg      <= 1'b1;
                data_reg      <= bus.in_data;
                wraddress_reg <= BASE_ADDRESS + offset_reg;
                offset_reg    <= offset_reg + 18'd1;
                if (x_reg == width_reg - 10'd1) begin
                    x_reg <= 10'd0;
                    y_reg <= y_reg + 10'd1;
                end else begin
                    x_reg <= x_reg + 10'd1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.wraddress = wraddress_reg;
    assign bus.data      = data_reg;
    assign bus.wren      = wren_reg;
    assign img_width     = width_reg;
    assign img_height    = height_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;
endmodule
